// File: rtl/grid_stream_loader.sv
// Assembles a WIDTH x DEPTH roll-occupancy matrix from an ASCII byte stream
// and holds it, with its roll count, until the consumer acknowledges it.
module grid_stream_loader #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    input  logic [7:0]                         in_data,
    output logic                               in_ready,
    output logic [WIDTH*DEPTH-1:0]             grid,
    output logic                               grid_valid,
    input  logic                               grid_ack,
    output logic [$clog2(WIDTH*DEPTH+1)-1:0]   roll_count,
    output logic                               err,
    input  logic                               err_clr
);

    localparam int CELLS = WIDTH * DEPTH;
    localparam int COL_W = $clog2(WIDTH + 1);
    localparam int ROW_W = $clog2(DEPTH + 1);
    localparam int CNT_W = $clog2(CELLS + 1);

    localparam logic [7:0] CH_ROLL  = 8'h40;
    localparam logic [7:0] CH_EMPTY = 8'h2E;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_EOT   = 8'h04;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        DONE  = 2'd1,
        ERROR = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CELLS-1:0]   grid_q, grid_d;
    logic [CNT_W-1:0]   roll_q, roll_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [CELLS-1:0]   wr_mask;

    // One-hot select of the cell at (row, col); all zero once col reaches WIDTH.
    always_comb begin
        for (int i = 0; i < CELLS; i++) begin
            wr_mask[i] = (i == int'(row_q) * WIDTH + int'(col_q)) && (int'(col_q) < WIDTH);
        end
    end

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        state_d = state_q;
        grid_d  = grid_q;
        roll_d  = roll_q;
        row_d   = row_q;
        col_d   = col_q;

        unique case (state_q)
            LOAD: begin
                if (in_valid) begin
                    case (in_data)
                        CH_ROLL, CH_EMPTY: begin
                            if (col_q == COL_W'(WIDTH)) begin
                                state_d = ERROR;
                            end else begin
                                if (in_data == CH_ROLL) begin
                                    grid_d = grid_q | wr_mask;
                                    roll_d = roll_q + CNT_W'(1);
                                end else begin
                                    grid_d = grid_q & ~wr_mask;
                                end
                                col_d = col_q + COL_W'(1);
                            end
                        end
                        CH_CR: ;
                        CH_LF: begin
                            col_d = '0;
                            row_d = row_q + ROW_W'(1);
                            if (row_q == ROW_W'(DEPTH - 1)) state_d = DONE;
                        end
                        CH_EOT:  state_d = DONE;
                        default: state_d = ERROR;
                    endcase
                end
            end
            DONE: begin
                if (grid_ack) begin
                    state_d = LOAD;
                    grid_d  = '0;
                    roll_d  = '0;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            ERROR: begin
                if (err_clr) begin
                    state_d = LOAD;
                    grid_d  = '0;
                    roll_d  = '0;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all update together on the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD;
            grid_q  <= '0;
            roll_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            grid_q  <= grid_d;
            roll_q  <= roll_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    assign in_ready   = (state_q == LOAD);
    assign grid_valid = (state_q == DONE);
    assign err        = (state_q == ERROR);
    assign grid       = grid_q;
    assign roll_count = roll_q;

endmodule

// File: tb/tb_grid_stream_loader.sv
// Directed self-checking bench for grid_stream_loader at WIDTH=4, DEPTH=3.
module tb_grid_stream_loader;

    localparam int WIDTH = 4;
    localparam int DEPTH = 3;
    localparam int CNT_W = $clog2(WIDTH * DEPTH + 1);

    logic                     clk;
    logic                     rst_n;
    logic                     in_valid;
    logic [7:0]               in_data;
    logic                     in_ready;
    logic [WIDTH*DEPTH-1:0]   grid;
    logic                     grid_valid;
    logic                     grid_ack;
    logic [CNT_W-1:0]         roll_count;
    logic                     err;
    logic                     err_clr;

    int checks = 0;
    int errors = 0;

    grid_stream_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .grid       (grid),
        .grid_valid (grid_valid),
        .grid_ack   (grid_ack),
        .roll_count (roll_count),
        .err        (err),
        .err_clr    (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sends each character of s; gap>0 inserts up to gap random idle cycles after each byte.
    task automatic send_str(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) begin
            in_valid = 1'b1;
            in_data  = s[i];
            step();
            if (gap > 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, gap)) step();
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic pulse_ack();
        grid_ack = 1'b1;
        step();
        grid_ack = 1'b0;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++;
        if (grid !== 12'h000 || roll_count !== 4'd0) begin
            errors++; $display("FAIL reset_grid: got grid=%h roll=%0d expected grid=000 roll=0", grid, roll_count);
        end
        checks++;
        if (grid_valid !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL reset_flags: got grid_valid=%b err=%b expected 0 0", grid_valid, err);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        send_str("@.@@\n....\n@@@@", 0);
        in_valid = 1'b1;
        in_data  = 8'h0A;
        checks++;
        if (grid_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b expected 0", grid_valid); end
        step();
        checks++;
        if (grid_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++; $display("FAIL basic_done: got grid_valid=%b in_ready=%b expected 1 0", grid_valid, in_ready);
        end
        checks++;
        if (grid !== 12'hF0D) begin errors++; $display("FAIL basic_grid: got %h expected f0d", grid); end
        checks++;
        if (roll_count !== 4'd7) begin errors++; $display("FAIL basic_roll: got %0d expected 7", roll_count); end
        in_data = 8'h40;
        step();
        step();
        in_valid = 1'b0;
        checks++;
        if (grid !== 12'hF0D || roll_count !== 4'd7 || grid_valid !== 1'b1) begin
            errors++; $display("FAIL basic_hold: got grid=%h roll=%0d valid=%b expected f0d 7 1", grid, roll_count, grid_valid);
        end
        pulse_ack();
        checks++;
        if (grid !== 12'h000 || roll_count !== 4'd0 || grid_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL basic_ack: got grid=%h roll=%0d valid=%b ready=%b expected 000 0 0 1",
                               grid, roll_count, grid_valid, in_ready);
        end
    endtask

    task automatic test_crlf();
        send_str("@", 0);
        checks++;
        if (grid !== 12'h001 || roll_count !== 4'd1) begin
            errors++; $display("FAIL crlf_first: got grid=%h roll=%0d expected 001 1", grid, roll_count);
        end
        send_str("\r", 0);
        checks++;
        if (grid !== 12'h001 || roll_count !== 4'd1 || grid_valid !== 1'b0) begin
            errors++; $display("FAIL crlf_cr: got grid=%h roll=%0d valid=%b expected 001 1 0", grid, roll_count, grid_valid);
        end
        send_str("\n.@\r\n", 0);
        checks++;
        if (grid_valid !== 1'b0) begin errors++; $display("FAIL crlf_not_done: got %b expected 0", grid_valid); end
        send_str("\n", 0);
        checks++;
        if (grid_valid !== 1'b1) begin errors++; $display("FAIL crlf_done: got %b expected 1", grid_valid); end
        checks++;
        if (grid !== 12'h021 || roll_count !== 4'd2) begin
            errors++; $display("FAIL crlf_grid: got grid=%h roll=%0d expected 021 2", grid, roll_count);
        end
        pulse_ack();
    endtask

    task automatic test_eot();
        send_str("@@", 0);
        send_str("\x04", 0);
        checks++;
        if (grid_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++; $display("FAIL eot_done: got valid=%b ready=%b expected 1 0", grid_valid, in_ready);
        end
        checks++;
        if (grid !== 12'h003 || roll_count !== 4'd2) begin
            errors++; $display("FAIL eot_grid: got grid=%h roll=%0d expected 003 2", grid, roll_count);
        end
        pulse_ack();
    endtask

    task automatic test_overflow();
        send_str("@@@@", 0);
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL ovf_early_err: got %b expected 0", err); end
        send_str("@", 0);
        checks++;
        if (err !== 1'b1 || in_ready !== 1'b0 || grid_valid !== 1'b0) begin
            errors++; $display("FAIL ovf_err: got err=%b ready=%b valid=%b expected 1 0 0", err, in_ready, grid_valid);
        end
        checks++;
        if (grid !== 12'h00F || roll_count !== 4'd4) begin
            errors++; $display("FAIL ovf_grid: got grid=%h roll=%0d expected 00f 4", grid, roll_count);
        end
        pulse_clr();
        checks++;
        if (err !== 1'b0 || grid !== 12'h000 || roll_count !== 4'd0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL ovf_clr: got err=%b grid=%h roll=%0d ready=%b expected 0 000 0 1",
                               err, grid, roll_count, in_ready);
        end
    endtask

    task automatic test_illegal();
        send_str(".@x", 0);
        checks++;
        if (err !== 1'b1 || grid !== 12'h002 || roll_count !== 4'd1) begin
            errors++; $display("FAIL illegal_err: got err=%b grid=%h roll=%0d expected 1 002 1", err, grid, roll_count);
        end
        pulse_ack();
        checks++;
        if (err !== 1'b1 || grid !== 12'h002 || in_ready !== 1'b0) begin
            errors++; $display("FAIL illegal_ack_ignored: got err=%b grid=%h ready=%b expected 1 002 0", err, grid, in_ready);
        end
        in_data = 8'h40;
        for (int i = 0; i < 6; i++) begin
            in_valid = i[0];
            step();
        end
        in_valid = 1'b0;
        checks++;
        if (grid !== 12'h002 || roll_count !== 4'd1 || err !== 1'b1) begin
            errors++; $display("FAIL illegal_frozen: got grid=%h roll=%0d err=%b expected 002 1 1", grid, roll_count, err);
        end
        pulse_clr();
        checks++;
        if (err !== 1'b0 || grid !== 12'h000 || in_ready !== 1'b1) begin
            errors++; $display("FAIL illegal_clr: got err=%b grid=%h ready=%b expected 0 000 1", err, grid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        send_str("@.@@\n", 2);
        pulse_clr();
        checks++;
        if (grid !== 12'h00D || roll_count !== 4'd3 || in_ready !== 1'b1) begin
            errors++; $display("FAIL gaps_clr_ignored: got grid=%h roll=%0d ready=%b expected 00d 3 1", grid, roll_count, in_ready);
        end
        send_str("....\n@@@@\n", 3);
        checks++;
        if (grid !== 12'hF0D || roll_count !== 4'd7 || grid_valid !== 1'b1) begin
            errors++; $display("FAIL gaps_grid: got grid=%h roll=%0d valid=%b expected f0d 7 1", grid, roll_count, grid_valid);
        end
        grid_ack = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h40;
        step();
        grid_ack = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (grid !== 12'h000 || roll_count !== 4'd0 || grid_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL ack_with_valid: got grid=%h roll=%0d valid=%b ready=%b expected 000 0 0 1",
                               grid, roll_count, grid_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        send_str("@@.", 0);
        checks++;
        if (roll_count !== 4'd2 || grid !== 12'h003) begin
            errors++; $display("FAIL midrst_pre: got grid=%h roll=%0d expected 003 2", grid, roll_count);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (grid !== 12'h000 || roll_count !== 4'd0 || in_ready !== 1'b1 || grid_valid !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL midrst_async: got grid=%h roll=%0d ready=%b valid=%b err=%b expected 000 0 1 0 0",
                               grid, roll_count, in_ready, grid_valid, err);
        end
        step();
        rst_n = 1'b1;
        step();
        send_str("@\x04", 0);
        checks++;
        if (grid !== 12'h001 || roll_count !== 4'd1 || grid_valid !== 1'b1) begin
            errors++; $display("FAIL midrst_restart: got grid=%h roll=%0d valid=%b expected 001 1 1", grid, roll_count, grid_valid);
        end
        pulse_ack();
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        grid_ack = 1'b0;
        err_clr  = 1'b0;
        test_reset();
        test_basic();
        test_crlf();
        test_eot();
        test_overflow();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/grid_stream_loader.md
Name: grid_stream_loader

Overview:
- Byte-stream front end for the paper-roll grid solvers: accepts the puzzle grid as ASCII bytes over a valid/ready handshake and assembles the WIDTH x DEPTH occupancy matrix.
- Presents the completed grid plus a roll count, then holds it until the consumer acknowledges.
- Sits upstream of the iterative removal engine and supplies its initial matrix.

Parameters:
WIDTH, 16, grid columns per row
DEPTH, 16, grid rows

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input byte valid
in_data  in  8  ASCII input byte
in_ready  out  1  loader can accept a byte
grid  out  WIDTH*DEPTH  row-major matrix; row i = grid[i*WIDTH +: WIDTH], bit j = column j; 1=roll '@', 0=empty
grid_valid  out  1  grid complete and stable
grid_ack  in  1  consumer has taken grid; loader rearms
roll_count  out  $clog2(WIDTH*DEPTH+1)  number of '@' in grid
err  out  1  malformed input detected
err_clr  in  1  clear error and rearm

Behaviour:
- Reset (async, rst_n=0): state LOAD, grid=0, roll_count=0, grid_valid=0, err=0, in_ready=1; row/col counters 0. Reset mid-load discards partial grid.
- Transfer occurs on a rising edge with in_valid && in_ready; effects are visible the following cycle.
- States:
  - LOAD: in_ready=1.
  - DONE: in_ready=0, grid_valid=1.
  - ERROR: in_ready=0, err=1.
- LOAD byte decode:
  - '@' (0x40): grid[row][col]=1, roll_count+1, col+1.
  - '.' (0x2E): grid[row][col]=0, col+1.
  - '\r' (0x0D): ignored, no counter change.
  - '\n' (0x0A): ends row. Columns col..WIDTH-1 stay 0 (short rows zero-padded); col=0, row+1. If row was DEPTH-1, go to DONE next cycle.
  - '\n' at col 0: produces an all-zero row and counts as a row.
  - EOT (0x04): ends grid early. Partial current row kept, remaining rows 0. Go to DONE regardless of row index.
  - Any other byte: go to ERROR.
  - '@' or '.' arriving when col==WIDTH (row overflow): go to ERROR; the byte is not written.
- DONE:
  - grid and roll_count held constant; in_valid ignored.
  - grid_ack=1 sampled: next cycle returns to LOAD with grid=0, roll_count=0, counters=0, grid_valid=0.
  - grid_valid rises exactly one cycle after the accepting edge of the terminating byte.
- ERROR:
  - grid and roll_count frozen at contents up to the offending byte.
  - err_clr=1: next cycle returns to LOAD with everything cleared, err=0.
  - grid_ack is ignored in ERROR; err_clr is ignored outside ERROR.
- Widths:
  - col counter is $clog2(WIDTH+1) bits and may reach WIDTH.
  - row counter is $clog2(DEPTH+1) bits.
  - roll_count cannot overflow, since max is WIDTH*DEPTH.
- No byte is lost or double-counted: the state change and the byte's effect share the same accepting edge.

Test Plan:
- WIDTH=4, DEPTH=3; send "@.@@\n....\n@@@@\n" with in_valid held -> grid_valid high the cycle after the last '\n'; row0=4'b1101, row1=0, row2=4'b1111; roll_count=7; in_ready=0.
- Short rows plus CRLF: "@\r\n.@\r\n\n" -> row0=4'b0001, row1=4'b0010, row2=0; roll_count=2; '\r' causes no counter change.
- Early EOT: "@@" then 0x04 -> DONE next cycle; row0=4'b0011, rows1-2=0; roll_count=2.
- Overflow: "@@@@@" -> err=1 after the 5th byte; row0=4'b1111; roll_count=4; in_ready=0. err_clr pulse -> LOAD, grid=0, err=0.
- Illegal byte 'x' mid-row -> ERROR. grid_ack pulse there has no effect; in_valid toggling with in_ready=0 changes nothing.
- Backpressure/rearm:
  - Random in_valid gaps produce the identical grid.
  - In DONE, grid_ack asserted together with in_valid -> the byte is not accepted; next cycle LOAD, grid=0.
  - rst_n pulsed low mid-row -> all outputs return to reset values immediately.
